period_meter: RTL

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 18 +
 rtl/period_meter_sync_edge.sv | 28 ++
 rtl/period_meter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

   localparam int unsigned CNT_W_DEFAULT   = 18;
   localparam int unsigned TIMEOUT_DEFAULT = 262143;
   // Nominal period is 2^(BASE_LOG2 - sel) clock cycles.
   localparam int unsigned BASE_LOG2       = 16;
   // Smallest period exponent the decode recognises (sel = 7).
   localparam int unsigned MIN_LOG2        = 9;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StMeas,
      StDone
   } state_e;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge pulse for an asynchronous input.
module period_meter_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic edge_o
);

   logic sync1_q, sync2_q, prev_q, edge_q;

   // Synchronize, delay one more stage, and register the rising-edge pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         edge_q  <= sync2_q & ~prev_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow divided clock in clk_i cycles and classifies it.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEFAULT,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sig_i,
   input  logic             start_i,
   input  logic [2:0]       exp_sel_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] period_o,
   output logic [2:0]       sel_o,
   output logic             pow2_o,
   output logic             match_o,
   output logic             timeout_o
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic [31:0]      cnt_ext;
   logic [2:0]       exp_sel_q;
   logic             edge_pulse;
   logic             term_cnt;

   logic             busy_q, valid_q, pow2_q, match_q, timeout_q;
   logic [CNT_W-1:0] period_q;
   logic [2:0]       sel_q;

   logic             pow2_d, match_d;
   logic [2:0]       sel_d;

   period_meter_sync_edge u_sync_edge (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .sig_i  (sig_i),
      .edge_o (edge_pulse)
   );

   // Saturating increment; the incremented value is the period if an edge lands this cycle.
   assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   assign cnt_ext  = 32'(cnt_inc);
   assign term_cnt = (cnt_ext == TIMEOUT);

   // Decode power-of-two periods 2^9..2^16 into sel, and compare against the expected period.
   always_comb begin
      pow2_d = 1'b0;
      sel_d  = 3'd0;
      for (int k = MIN_LOG2; k <= BASE_LOG2; k++) begin
         if (cnt_ext == (32'd1 << k)) begin
            pow2_d = 1'b1;
            sel_d  = 3'(BASE_LOG2 - k);
         end
      end
      match_d = (cnt_ext == (32'd1 << (BASE_LOG2 - 32'(exp_sel_q))));
   end

   // Measurement FSM with registered result outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         exp_sel_q <= 3'd0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         period_q  <= '0;
         sel_q     <= 3'd0;
         pow2_q    <= 1'b0;
         match_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  exp_sel_q <= exp_sel_i;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= StArm;
               end
            end
            StArm: begin
               // An edge wins over a simultaneous terminal count.
               if (edge_pulse) begin
                  cnt_q   <= '0;
                  state_q <= StMeas;
               end else if (term_cnt) begin
                  period_q  <= '0;
                  sel_q     <= 3'd0;
                  pow2_q    <= 1'b0;
                  match_q   <= 1'b0;
                  timeout_q <= 1'b1;
                  valid_q   <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StDone;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StMeas: begin
               if (edge_pulse) begin
                  period_q <= cnt_inc;
                  sel_q    <= sel_d;
                  pow2_q   <= pow2_d;
                  match_q  <= match_d;
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= StDone;
               end else if (term_cnt) begin
                  period_q  <= '0;
                  sel_q     <= 3'd0;
                  pow2_q    <= 1'b0;
                  match_q   <= 1'b0;
                  timeout_q <= 1'b1;
                  valid_q   <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StDone;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign valid_o   = valid_q;
   assign period_o  = period_q;
   assign sel_o     = sel_q;
   assign pow2_o    = pow2_q;
   assign match_o   = match_q;
   assign timeout_o = timeout_q;

endmodule
